uart_tx_sched: RTL and testbench

Scheduler and sequencer for the `uart_transmitter`. It accepts bytes from two requesters (CPU store path, index 0; debug/monitor path, index 1) through valid/ready handshakes, arbitrates round-robin into a 4-entry FIFO, and drives the transmitter's `data_in`, `load_data_reg`, `transfer_byte`, `byte_ready` and `stop_2` pins one frame at a time. It tracks frame progress through the transmitter's `bit_cnt_out` and flags a stalled transmitter.

---
 rtl/uart_tx_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Feeds a uart_transmitter one frame at a time from two byte requesters.
// Requester 0 is the CPU store path and requester 1 is the debug/monitor path.
// A round-robin arbiter pushes at most one byte per cycle into a DEPTH-entry
// FIFO. A Moore sequencer pops the head and steps the transmitter through
// load -> start -> data -> stop. It watches the transmitter's bit count and
// flags a transmitter that never reaches bit 8.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   TMO    WAIT-state cycle limit before err_timeout
//
// Ports
//   clk            clock
//   rst            asynchronous, active-low reset
//   req_valid[1:0] per-requester byte valid
//   req_data0/1    requester bytes
//   req_ready[1:0] per-requester accept (combinational from req_valid)
//   cfg_stop2      two stop bits; sampled when a byte is popped
//   err_clr        clears err_timeout (a same-cycle set wins)
//   tx_data        -> data_in        (current byte, stable for the frame)
//   tx_load        -> load_data_reg  (1-cycle pulse in START)
//   tx_transfer    -> transfer_byte  (1-cycle pulse in START)
//   tx_byte_ready  -> byte_ready     (1-cycle pulse in ARM)
//   tx_stop2       -> stop_2         (stop2 latched at pop)
//   tx_bit_cnt     <- bit_cnt_out
//   busy           sequencer not IDLE
//   fifo_count     FIFO occupancy
//   err_timeout    sticky stalled-transmitter flag
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DEPTH = 4,
    parameter int TMO   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [7:0]             req_data0,
    input  logic [7:0]             req_data1,
    output logic [1:0]             req_ready,
    input  logic                   cfg_stop2,
    input  logic                   err_clr,
    output logic [7:0]             tx_data,
    output logic                   tx_load,
    output logic                   tx_transfer,
    output logic                   tx_byte_ready,
    output logic                   tx_stop2,
    input  logic [3:0]             tx_bit_cnt,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_timeout
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 8;
    localparam int AW        = $clog2(DEPTH);
    localparam int WW        = $clog2(TMO + 1);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [WW-1:0] wcnt_t;

    typedef struct packed {
        logic             vld;
        logic [VEC_W-1:0] data;
    } req_t;

    typedef enum logic [2:0] {IDLE, START, ARM, WAIT, STOP} state_t;

    // ---------------------------------------------------------------------
    // Arbiter
    // ---------------------------------------------------------------------
    req_t [NUM_LANES-1:0] req;
    logic [NUM_LANES-1:0] grant;
    logic [NUM_LANES-1:0] prio;
    logic                 last_srv;   // index of the requester served last
    logic                 space;
    logic                 push;
    logic [VEC_W-1:0]     push_data;

    // FIFO / sequencer state referenced by the arbiter
    state_t               state;
    cnt_t                 count;
    logic                 full;
    logic                 pop;

    assign req[0] = '{vld: req_valid[0], data: req_data0};
    assign req[1] = '{vld: req_valid[1], data: req_data1};

    // The requester not served last has priority on a tie.
    assign prio = last_srv ? 2'b01 : 2'b10;

    // A pop frees a slot for the same cycle's push only when the FIFO is
    // full. Otherwise ready follows the registered occupancy. pop depends
    // only on registered state, so no loop forms through req_valid.
    assign space = ~full | pop;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign grant[i]     = req[i].vld & (~req[NUM_LANES-1-i].vld | prio[i]);
        assign req_ready[i] = grant[i] & space;
    end

    assign push      = |(req_valid & req_ready);
    assign push_data = grant[1] ? req[1].data : req[0].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_srv <= 1'b1;   // requester 0 wins the first tie
        end else if (push) begin
            last_srv <= grant[1];
        end
    end

    // ---------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------
    logic [DEPTH-1:0][VEC_W-1:0] mem;
    ptr_t                        wr_ptr;
    ptr_t                        rd_ptr;

    assign full       = (count == cnt_t'(DEPTH));
    assign pop        = (state == IDLE) && (count != '0);
    assign fifo_count = count;

    // Pointers are AW bits wide, so they wrap modulo DEPTH without extra logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    logic [VEC_W-1:0] cur_byte;
    logic             stop2_q;
    wcnt_t            wcnt;
    logic [1:0]       scnt;

    assign tx_data  = cur_byte;
    assign tx_stop2 = stop2_q;
    assign busy     = (state != IDLE);

    // Strobes are registered and set on the transition into their state, so
    // each one is high for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cur_byte      <= '0;
            stop2_q       <= 1'b0;
            wcnt          <= '0;
            scnt          <= '0;
            tx_load       <= 1'b0;
            tx_transfer   <= 1'b0;
            tx_byte_ready <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            tx_load       <= 1'b0;
            tx_transfer   <= 1'b0;
            tx_byte_ready <= 1'b0;
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_byte    <= mem[rd_ptr];
                        stop2_q     <= cfg_stop2;
                        tx_load     <= 1'b1;
                        tx_transfer <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    tx_byte_ready <= 1'b1;
                    state         <= ARM;
                end
                ARM: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wcnt <= wcnt + wcnt_t'(1);
                    if (tx_bit_cnt == 4'd8) begin
                        scnt  <= stop2_q ? 2'd2 : 2'd1;
                        state <= STOP;
                    end else if (wcnt == wcnt_t'(TMO - 1)) begin
                        // wcnt reaches TMO on this edge. The byte is dropped,
                        // and this set overrides a same-cycle err_clr.
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                STOP: begin
                    if (scnt == 2'd1) begin
                        state <= IDLE;
                    end else begin
                        scnt <= scnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched. A table of per-cycle vectors covers the
// first frame. Hand-written sequences cover round-robin order, FIFO full with
// a same-cycle push and pop, two stop bits, timeout, and reset mid-frame.
// A small transmitter model drives tx_bit_cnt and a serial line.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] req_data0 = 8'h00;
    logic [7:0] req_data1 = 8'h00;
    logic [1:0] req_ready;
    logic       cfg_stop2 = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] tx_data;
    logic       tx_load, tx_transfer, tx_byte_ready, tx_stop2;
    logic [3:0] tx_bit_cnt;
    logic       busy;
    logic [2:0] fifo_count;
    logic       err_timeout;

    always #5 clk = ~clk;

    uart_tx_sched #(.DEPTH(4), .TMO(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .cfg_stop2(cfg_stop2), .err_clr(err_clr),
        .tx_data(tx_data), .tx_load(tx_load), .tx_transfer(tx_transfer),
        .tx_byte_ready(tx_byte_ready), .tx_stop2(tx_stop2),
        .tx_bit_cnt(tx_bit_cnt), .busy(busy), .fifo_count(fifo_count),
        .err_timeout(err_timeout)
    );

    // Transmitter model: capture on load, start bit after byte_ready,
    // 8 data bits LSB first, then idle-high. The bit count holds at 8.
    logic [3:0] m_cnt;
    logic       m_line;
    logic [7:0] m_sh;
    logic       m_run;
    logic       tie0 = 1'b0;

    assign tx_bit_cnt = tie0 ? 4'd0 : m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= 4'd0; m_line <= 1'b1; m_sh <= 8'h00; m_run <= 1'b0;
        end else begin
            if (tx_load) m_sh <= tx_data;
            if (tx_byte_ready) begin
                m_line <= 1'b0; m_cnt <= 4'd0; m_run <= 1'b1;
            end else if (m_run && m_cnt < 4'd8) begin
                m_line <= m_sh[m_cnt[2:0]]; m_cnt <= m_cnt + 4'd1;
            end else if (m_run) begin
                m_line <= 1'b1; m_run <= 1'b0;
            end
        end
    end

    int nvec = 0;
    int nerr = 0;
    int maxcnt = 0;
    int pp_seen = 0;
    logic [7:0] src0[$], src1[$], acc[$], txq[$];

    always @(negedge clk) if (rst && tx_load) txq.push_back(tx_data);

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00; err_clr = 1'b0; tie0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || fifo_count != 3'd0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check({name, ".idle"}, int'(n < 300), 1);
    endtask

    task automatic wait_tx(input string name, input int want);
        int n = 0;
        while (txq.size() < want && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check({name, ".txcount"}, txq.size(), want);
    endtask

    task automatic push_one(input logic [7:0] d);
        @(negedge clk);
        req_valid = 2'b01; req_data0 = d;
        #1;
        check("push.ready", int'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 2'b00;
    endtask

    // Offers the queued bytes each cycle. After a full-FIFO pop cycle it checks
    // that the push landed while count stayed at DEPTH.
    task automatic run_src(input int budget, input bit chk_full);
        int cyc = 0;
        bit pp;
        while ((src0.size() != 0 || src1.size() != 0) && cyc < budget) begin
            @(negedge clk);
            req_valid = {src1.size() != 0, src0.size() != 0};
            req_data0 = (src0.size() != 0) ? src0[0] : 8'h00;
            req_data1 = (src1.size() != 0) ? src1[0] : 8'h00;
            #1;
            pp = 1'b0;
            check("ready.onehot0", int'($onehot0(req_ready)), 1);
            if (chk_full && fifo_count == 3'd4) begin
                if (busy) check("full.ready", int'(req_ready), 0);
                else begin
                    check("fullpop.ready", int'(req_ready), 1);
                    pp = 1'b1;
                end
            end
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
            if (req_valid[0] && req_ready[0]) acc.push_back(src0.pop_front());
            else if (req_valid[1] && req_ready[1]) acc.push_back(src1.pop_front());
            @(posedge clk); #1;
            req_valid = 2'b00;
            if (pp) begin
                pp_seen++;
                check("fullpop.count", int'(fifo_count), 4);
                check("fullpop.load", int'(tx_load), 1);
            end
            cyc++;
        end
        check("src.drained", int'(cyc < budget), 1);
    endtask

    typedef struct packed {
        logic [1:0] vld;
        logic [7:0] d0;
        logic [1:0] ready;
        logic       load;
        logic       xfer;
        logic       br;
        logic       busy;
        logic [2:0] cnt;
        logic       line;
        logic [7:0] txd;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [7:0] rr_exp[6];
        int fin;

        //        vld    d0     rdy   ld xf br bsy cnt  line txd
        tbl[0]  = '{2'b01, 8'hA5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00};
        tbl[1]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00};
        tbl[2]  = '{2'b00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        tbl[3]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5};
        tbl[4]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5};
        tbl[5]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        tbl[6]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5};
        tbl[7]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        tbl[8]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5};
        tbl[9]  = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5};
        tbl[10] = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        tbl[11] = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5};
        tbl[12] = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        tbl[13] = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5};
        tbl[14] = '{2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'hA5};

        // Reset values
        #12;
        check("rst.ready", int'(req_ready), 0);
        check("rst.tx_data", int'(tx_data), 0);
        check("rst.tx_strobes", int'({tx_load, tx_transfer, tx_byte_ready, tx_stop2}), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.count", int'(fifo_count), 0);
        check("rst.err", int'(err_timeout), 0);
        @(negedge clk); rst = 1'b1;

        // Single 0xA5 frame, one stop bit, cycle by cycle
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            req_valid = tbl[i].vld; req_data0 = tbl[i].d0;
            #1;
            check($sformatf("a5[%0d].ready", i), int'(req_ready), int'(tbl[i].ready));
            check($sformatf("a5[%0d].load", i), int'(tx_load), int'(tbl[i].load));
            check($sformatf("a5[%0d].xfer", i), int'(tx_transfer), int'(tbl[i].xfer));
            check($sformatf("a5[%0d].bready", i), int'(tx_byte_ready), int'(tbl[i].br));
            check($sformatf("a5[%0d].busy", i), int'(busy), int'(tbl[i].busy));
            check($sformatf("a5[%0d].count", i), int'(fifo_count), int'(tbl[i].cnt));
            check($sformatf("a5[%0d].line", i), int'(m_line), int'(tbl[i].line));
            check($sformatf("a5[%0d].tx_data", i), int'(tx_data), int'(tbl[i].txd));
        end

        // Round robin: both requesters hold valid, 3 bytes each
        do_reset();
        txq.delete(); acc.delete();
        src0 = '{8'h11, 8'h11, 8'h11};
        src1 = '{8'h22, 8'h22, 8'h22};
        rr_exp = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};
        run_src(200, 1'b0);
        wait_tx("rr", 6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc.size()) check($sformatf("rr.acc[%0d]", i), int'(acc[i]), int'(rr_exp[i]));
            if (i < txq.size()) check($sformatf("rr.tx[%0d]", i), int'(txq[i]), int'(rr_exp[i]));
        end
        wait_idle("rr");

        // Six pushes with the first frame in flight: fill, hold, push on pop
        txq.delete(); acc.delete(); maxcnt = 0; pp_seen = 0;
        src0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_src(200, 1'b1);
        check("full.maxcount", maxcnt, 4);
        check("full.pushpop_seen", pp_seen, 1);
        wait_tx("full", 6);
        for (int i = 0; i < txq.size(); i++)
            check($sformatf("full.tx[%0d]", i), int'(txq[i]), i + 1);
        wait_idle("full");

        // Two stop bits; cfg_stop2 toggles after the pop
        cfg_stop2 = 1'b1;
        push_one(8'h3C);
        fin = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            cfg_stop2 = ~cfg_stop2;
            if (!busy) begin fin = c; break; end
            check($sformatf("stop2.tx_stop2@%0d", c), int'(tx_stop2), 1);
            if (c == 1) check("stop2.tx_data", int'(tx_data), 8'h3C);
        end
        check("stop2.frame_cycles", fin, 14);
        cfg_stop2 = 1'b0;
        wait_idle("stop2");

        // Timeout with tx_bit_cnt stuck at 0; set wins over same-cycle clear
        tie0 = 1'b1;
        push_one(8'h5A);
        repeat (14) @(posedge clk);
        #1;
        check("tmo.err_before", int'(err_timeout), 0);
        check("tmo.busy_before", int'(busy), 1);
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        check("tmo.err_set", int'(err_timeout), 1);
        check("tmo.busy_after", int'(busy), 0);
        check("tmo.count_after", int'(fifo_count), 0);
        repeat (3) @(posedge clk);
        #1;
        check("tmo.err_sticky", int'(err_timeout), 1);
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        check("tmo.err_cleared", int'(err_timeout), 0);
        tie0 = 1'b0;

        // Reset in WAIT with 3 bytes queued
        cfg_stop2 = 1'b1;
        src0 = '{8'h71, 8'h72, 8'h73, 8'h74};
        run_src(50, 1'b0);
        check("mid.busy_pre", int'(busy), 1);
        check("mid.count_pre", int'(fifo_count), 3);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("mid.busy", int'(busy), 0);
        check("mid.count", int'(fifo_count), 0);
        check("mid.tx_data", int'(tx_data), 0);
        check("mid.tx_strobes", int'({tx_load, tx_transfer, tx_byte_ready, tx_stop2}), 0);
        cfg_stop2 = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid.flushed_busy", int'(busy), 0);
        check("mid.flushed_count", int'(fifo_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
